// File: rtl/bcd_display_scan_pkg.sv
// Shared types and constants for the 3-digit BCD scanned 7-segment display.
package bcd_display_scan_pkg;

    localparam int unsigned NUM_DIGITS = 3;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned SEG_W      = 7;

    typedef enum logic [1:0] {
        S_U = 2'd0,
        S_D = 2'd1,
        S_C = 2'd2
    } scan_state_e;

    // Hundreds/tens/units value as one bus payload
    typedef struct packed {
        logic [DIGIT_W-1:0] c;
        logic [DIGIT_W-1:0] d;
        logic [DIGIT_W-1:0] u;
    } bcd_val_t;

    // Active-high segment patterns, bit 0 = a ... bit 6 = g
    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_display_scan_if.sv
// Load/display bus between the value source and the scanned display driver.
interface bcd_display_scan_if;
    import bcd_display_scan_pkg::*;

    logic               LOAD;
    logic [DIGIT_W-1:0] C;
    logic [DIGIT_W-1:0] D;
    logic [DIGIT_W-1:0] U;
    logic [SEG_W-1:0]   SEG;
    logic [NUM_DIGITS-1:0] AN;
    logic               PEND;
    logic               UPD;

    modport master (
        output LOAD, C, D, U,
        input  SEG, AN, PEND, UPD
    );

    modport slave (
        input  LOAD, C, D, U,
        output SEG, AN, PEND, UPD
    );

endinterface

// File: rtl/bcd_display_scan_seg7_decode.sv
// Combinational BCD digit to active-high 7-segment pattern; non-decimal codes show a dash.
module seg7_decode
    import bcd_display_scan_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [SEG_W-1:0]   o_seg_c
);

    always_comb begin
        o_seg_c = SEG_DASH;
        case (i_digit)
            4'd0:    o_seg_c = SEG_0;
            4'd1:    o_seg_c = SEG_1;
            4'd2:    o_seg_c = SEG_2;
            4'd3:    o_seg_c = SEG_3;
            4'd4:    o_seg_c = SEG_4;
            4'd5:    o_seg_c = SEG_5;
            4'd6:    o_seg_c = SEG_6;
            4'd7:    o_seg_c = SEG_7;
            4'd8:    o_seg_c = SEG_8;
            4'd9:    o_seg_c = SEG_9;
            default: o_seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Tear-free 3-digit multiplexed 7-segment driver: prescaler, digit scan FSM, frame-aligned load.
// Optional leading-zero blanking on the C/D digits via `define LEADING_ZERO_BLANK_EN.
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int unsigned DIV        = 50000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    bcd_display_scan_if.slave bus
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [SEG_W-1:0]      SEG_RST = ACTIVE_LOW ? ~SEG_0 : SEG_0;
    localparam logic [NUM_DIGITS-1:0] AN_RST  = ACTIVE_LOW ? 3'b110 : 3'b001;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;
    scan_state_e      r_state;
    scan_state_e      w_state_nxt;
    logic             w_boundary;

    bcd_val_t r_disp;
    bcd_val_t r_pend;
    bcd_val_t w_disp_nxt;
    bcd_val_t w_pend_nxt;
    bcd_val_t w_in;
    logic     r_pend_flag;
    logic     w_pend_flag_nxt;
    logic     r_upd;
    logic     w_upd_nxt;

    logic [DIGIT_W-1:0]    w_digit;
    logic                  w_blank;
    logic [SEG_W-1:0]      w_seg_dec;
    logic [SEG_W-1:0]      w_seg_hi;
    logic [NUM_DIGITS-1:0] w_an_hi;
    logic [SEG_W-1:0]      r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    // Refresh prescaler: one tick per digit slot
    assign w_tick = (r_cnt == CNT_MAX);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Scan FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_U;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Scan FSM next state
    always_comb begin
        w_state_nxt = r_state;
        if (w_tick) begin
            case (r_state)
                S_U:     w_state_nxt = S_D;
                S_D:     w_state_nxt = S_C;
                S_C:     w_state_nxt = S_U;
                default: w_state_nxt = S_U;
            endcase
        end
    end

    assign w_boundary = w_tick && (r_state == S_C);
    assign w_in       = '{c: bus.C, d: bus.D, u: bus.U};

    // Load handshake: a load on the boundary bypasses the pending stage
    always_comb begin
        w_disp_nxt      = r_disp;
        w_pend_nxt      = r_pend;
        w_pend_flag_nxt = r_pend_flag;
        w_upd_nxt       = 1'b0;
        if (bus.LOAD && w_boundary) begin
            w_disp_nxt      = w_in;
            w_pend_flag_nxt = 1'b0;
            w_upd_nxt       = 1'b1;
        end else if (bus.LOAD) begin
            w_pend_nxt      = w_in;
            w_pend_flag_nxt = 1'b1;
        end else if (w_boundary && r_pend_flag) begin
            w_disp_nxt      = r_pend;
            w_pend_flag_nxt = 1'b0;
            w_upd_nxt       = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_disp      <= '0;
            r_pend      <= '0;
            r_pend_flag <= 1'b0;
            r_upd       <= 1'b0;
        end else begin
            r_disp      <= w_disp_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_flag <= w_pend_flag_nxt;
            r_upd       <= w_upd_nxt;
        end
    end

    // Output decode for the state and value that will hold after this edge
    always_comb begin
        w_digit = w_disp_nxt.u;
        w_an_hi = 3'b001;
        w_blank = 1'b0;
        case (w_state_nxt)
            S_D: begin
                w_digit = w_disp_nxt.d;
                w_an_hi = 3'b010;
                w_blank = BLANK_EN && (w_disp_nxt.c == '0) && (w_disp_nxt.d == '0);
            end
            S_C: begin
                w_digit = w_disp_nxt.c;
                w_an_hi = 3'b100;
                w_blank = BLANK_EN && (w_disp_nxt.c == '0);
            end
            default: begin
                w_digit = w_disp_nxt.u;
                w_an_hi = 3'b001;
            end
        endcase
    end

    seg7_decode u_seg7_decode (
        .i_digit (w_digit),
        .o_seg_c (w_seg_dec)
    );

    assign w_seg_hi = w_blank ? SEG_BLANK : w_seg_dec;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_seg <= SEG_RST;
            r_an  <= AN_RST;
        end else begin
            r_seg <= ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
            r_an  <= ACTIVE_LOW ? ~w_an_hi  : w_an_hi;
        end
    end

    assign bus.SEG  = r_seg;
    assign bus.AN   = r_an;
    assign bus.PEND = r_pend_flag;
    assign bus.UPD  = r_upd;

endmodule
